// File: rtl/seven_seg_decoder.sv
// -----------------------------------------------------------------------------
// seven_seg_decoder
//
// Recovers a 4-bit digit from an active-high A..G seven-segment pattern. It is
// the inverse of the board's binary-to-7-segment encoder. It is used for
// loop-back checking of the display path and for reading segment-driven
// peripherals.
//
// The raw segment lines are glitch-filtered. A pattern is accepted only after
// it has matched the sampled copy for STABLE_CYCLES consecutive clocks.
// Each accepted pattern is compared with the previously accepted one:
//   - Re-acquiring the same glyph (for example after a glitch) is silent.
//   - A new valid digit pulses o_Valid.
//   - A new unrecognised, non-blank glyph pulses o_Error and bumps a
//     saturating error counter.
//
// Optional build macro:
//   SEG7_HEX_EN  - when defined, the hex glyphs A b C d E F also decode as
//                  valid digits. When undefined, they are flagged as errors.
//
// Parameters:
//   STABLE_CYCLES  equal consecutive samples needed before acceptance (>= 1)
//   ERR_CNT_W      width of the saturating error counter
//
// Ports:
//   i_Clk            system clock, rising edge
//   i_Reset          synchronous active-high reset
//   i_Segment_A..G   segment inputs, active high (A = bit 6 ... G = bit 0)
//   o_Binary_Num     last accepted digit value
//   o_Valid          1-cycle pulse: new valid digit accepted
//   o_Error          1-cycle pulse: new unrecognised non-blank glyph accepted
//   o_Blank          level: last accepted pattern was all segments off
//   o_Locked         level: a stable pattern is currently locked
//   o_Error_Count    saturating count of o_Error pulses
// -----------------------------------------------------------------------------
module seven_seg_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic                 i_Segment_A,
    input  logic                 i_Segment_B,
    input  logic                 i_Segment_C,
    input  logic                 i_Segment_D,
    input  logic                 i_Segment_E,
    input  logic                 i_Segment_F,
    input  logic                 i_Segment_G,
    output logic [3:0]           o_Binary_Num,
    output logic                 o_Valid,
    output logic                 o_Error,
    output logic                 o_Blank,
    output logic                 o_Locked,
    output logic [ERR_CNT_W-1:0] o_Error_Count
);

    localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    // Returns {recognised, digit} for a segment pattern.
    function automatic logic [4:0] decode(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'h7E:   res = {1'b1, 4'h0};
            7'h30:   res = {1'b1, 4'h1};
            7'h6D:   res = {1'b1, 4'h2};
            7'h79:   res = {1'b1, 4'h3};
            7'h33:   res = {1'b1, 4'h4};
            7'h5B:   res = {1'b1, 4'h5};
            7'h5F:   res = {1'b1, 4'h6};
            7'h70:   res = {1'b1, 4'h7};
            7'h7F:   res = {1'b1, 4'h8};
            7'h7B:   res = {1'b1, 4'h9};
`ifdef SEG7_HEX_EN
            7'h77:   res = {1'b1, 4'hA};
            7'h1F:   res = {1'b1, 4'hB};
            7'h4E:   res = {1'b1, 4'hC};
            7'h3D:   res = {1'b1, 4'hD};
            7'h4F:   res = {1'b1, 4'hE};
            7'h47:   res = {1'b1, 4'hF};
`endif
            default: res = {1'b0, 4'h0};
        endcase
        return res;
    endfunction

    logic [6:0]           seg_in;
    logic [6:0]           seg_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    state_t               state_q, state_d;
    logic [6:0]           last_q, last_d;
    logic                 last_vld_q, last_vld_d;
    logic [3:0]           num_q, num_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 blank_q, blank_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 accept;
    logic [4:0]           dec;

    assign seg_in = {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                     i_Segment_E, i_Segment_F, i_Segment_G};

    always_comb begin
        cnt_d      = cnt_q;
        state_d    = state_q;
        last_d     = last_q;
        last_vld_d = last_vld_q;
        num_d      = num_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        blank_d    = blank_q;
        err_cnt_d  = err_cnt_q;
        dec        = decode(seg_q);

        // Stability counter: any disagreement with the sampled copy restarts it.
        if (seg_in != seg_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Acceptance happens on the edge where the counter reaches its limit.
        accept = (state_q == S_SETTLE) && (cnt_d == CNT_MAX);

        case (state_q)
            S_IDLE:   state_d = S_SETTLE;
            S_SETTLE: if (accept) state_d = S_LOCKED;
            S_LOCKED: if (seg_in != seg_q) state_d = S_SETTLE;
            default:  state_d = S_IDLE;
        endcase

        if (accept) begin
            last_d     = seg_q;
            last_vld_d = 1'b1;
            // Re-locking onto the glyph already reported stays silent.
            if (!(last_vld_q && (seg_q == last_q))) begin
                if (dec[4]) begin
                    num_d   = dec[3:0];
                    valid_d = 1'b1;
                    blank_d = 1'b0;
                end else if (seg_q == 7'h00) begin
                    blank_d = 1'b1;
                end else begin
                    err_d   = 1'b1;
                    blank_d = 1'b0;
                    if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            seg_q      <= '0;
            cnt_q      <= '0;
            state_q    <= S_IDLE;
            last_q     <= '0;
            last_vld_q <= 1'b0;
            num_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            blank_q    <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            seg_q      <= seg_in;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            num_q      <= num_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            blank_q    <= blank_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign o_Binary_Num  = num_q;
    assign o_Valid       = valid_q;
    assign o_Error       = err_q;
    assign o_Blank       = blank_q;
    assign o_Locked      = (state_q == S_LOCKED);
    assign o_Error_Count = err_cnt_q;

endmodule

// File: tb/tb_seven_seg_decoder.sv
module tb_seven_seg_decoder;

    localparam int STABLE = 4;
    localparam int ACCEPT = STABLE + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sa = 1'b0, sb_ = 1'b0, sc = 1'b0, sd = 1'b0;
    logic       se = 1'b0, sf = 1'b0, sg = 1'b0;
    logic [3:0] o_Binary_Num;
    logic       o_Valid, o_Error, o_Blank, o_Locked;
    logic [7:0] o_Error_Count;

    always #5 clk = ~clk;

    seven_seg_decoder #(.STABLE_CYCLES(STABLE), .ERR_CNT_W(8)) dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Segment_A   (sa),
        .i_Segment_B   (sb_),
        .i_Segment_C   (sc),
        .i_Segment_D   (sd),
        .i_Segment_E   (se),
        .i_Segment_F   (sf),
        .i_Segment_G   (sg),
        .o_Binary_Num  (o_Binary_Num),
        .o_Valid       (o_Valid),
        .o_Error       (o_Error),
        .o_Blank       (o_Blank),
        .o_Locked      (o_Locked),
        .o_Error_Count (o_Error_Count)
    );

    typedef struct {
        logic       is_err;
        logic [3:0] val;
        int         cnt;
    } exp_t;

    exp_t sbq[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [6:0] m_last;
    logic       m_last_vld;
    logic [3:0] m_val;
    logic       m_blank;
    int         m_cnt;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ref_decode(input logic [6:0] p, output logic ok, output logic [3:0] d);
        ok = 1'b1;
        d  = 4'h0;
        case (p)
            7'h7E: d = 4'd0;
            7'h30: d = 4'd1;
            7'h6D: d = 4'd2;
            7'h79: d = 4'd3;
            7'h33: d = 4'd4;
            7'h5B: d = 4'd5;
            7'h5F: d = 4'd6;
            7'h70: d = 4'd7;
            7'h7F: d = 4'd8;
            7'h7B: d = 4'd9;
`ifdef SEG7_HEX_EN
            7'h77: d = 4'hA;
            7'h1F: d = 4'hB;
            7'h4E: d = 4'hC;
            7'h3D: d = 4'hD;
            7'h4F: d = 4'hE;
            7'h47: d = 4'hF;
`endif
            default: ok = 1'b0;
        endcase
    endtask

    task automatic model_reset();
        m_last     = 7'h00;
        m_last_vld = 1'b0;
        m_val      = 4'h0;
        m_blank    = 1'b0;
        m_cnt      = 0;
        sbq.delete();
    endtask

    // Model one acceptance of pattern p; queue the pulse it should produce.
    task automatic model_accept(input logic [6:0] p);
        logic       ok;
        logic [3:0] d;
        exp_t       e;
        ref_decode(p, ok, d);
        if (!(m_last_vld && p == m_last)) begin
            if (ok) begin
                m_val    = d;
                m_blank  = 1'b0;
                e.is_err = 1'b0;
                e.val    = d;
                e.cnt    = m_cnt;
                sbq.push_back(e);
            end else if (p == 7'h00) begin
                m_blank = 1'b1;
            end else begin
                m_blank = 1'b0;
                if (m_cnt < 255) m_cnt++;
                e.is_err = 1'b1;
                e.val    = m_val;
                e.cnt    = m_cnt;
                sbq.push_back(e);
            end
        end
        m_last     = p;
        m_last_vld = 1'b1;
    endtask

    task automatic set_seg(input logic [6:0] p);
        {sa, sb_, sc, sd, se, sf, sg} = p;
    endtask

    // One clock; any pulse seen is matched against the scoreboard head.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (o_Valid === 1'b1 || o_Error === 1'b1) begin
            chk("pulse_exclusive", int'(o_Valid & o_Error), 0);
            if (sbq.size() == 0) begin
                chk("unexpected_pulse", int'({o_Valid, o_Error}), 0);
            end else begin
                e = sbq.pop_front();
                chk("pulse_kind_err", int'(o_Error), int'(e.is_err));
                chk("pulse_value", int'(o_Binary_Num), int'(e.val));
                chk("pulse_err_count", int'(o_Error_Count), e.cnt);
            end
        end
    endtask

    task automatic check_levels(input string tag, input logic exp_locked);
        chk({tag, "_value"}, int'(o_Binary_Num), int'(m_val));
        chk({tag, "_blank"}, int'(o_Blank), int'(m_blank));
        chk({tag, "_err_count"}, int'(o_Error_Count), m_cnt);
        chk({tag, "_locked"}, int'(o_Locked), int'(exp_locked));
    endtask

    task automatic drive(input string tag, input logic [6:0] p, input int hold);
        set_seg(p);
        if (hold >= ACCEPT) model_accept(p);
        repeat (hold) tick();
        chk({tag, "_pending"}, sbq.size(), 0);
        check_levels(tag, hold >= ACCEPT);
        $display("step %s pattern=%02h hold=%0d value=%0h blank=%0b errcnt=%0d locked=%0b",
                 tag, p, hold, o_Binary_Num, o_Blank, o_Error_Count, o_Locked);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rst_value"}, int'(o_Binary_Num), 0);
        chk({tag, "_rst_valid"}, int'(o_Valid), 0);
        chk({tag, "_rst_error"}, int'(o_Error), 0);
        chk({tag, "_rst_blank"}, int'(o_Blank), 0);
        chk({tag, "_rst_locked"}, int'(o_Locked), 0);
        chk({tag, "_rst_errcnt"}, int'(o_Error_Count), 0);
    endtask

    logic [6:0] digits [10];

    initial begin
        digits = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
        model_reset();

        // Test 1: reset state, then exact acceptance latency for 7'h30
        rst = 1'b1;
        set_seg(7'h30);
        repeat (2) tick();
        check_reset_values("t1");
        rst = 1'b0;
        model_accept(7'h30);
        for (int i = 1; i < ACCEPT; i++) begin
            tick();
            chk("t1_no_early_pulse", sbq.size(), 1);
            chk("t1_not_locked_early", int'(o_Locked), 0);
        end
        tick();
        chk("t1_pulse_on_5th_edge", sbq.size(), 0);
        check_levels("t1", 1'b1);
        $display("step t1 pattern=30 value=%0h locked=%0b", o_Binary_Num, o_Locked);

        // Test 2: sweep 0..9
        for (int i = 0; i < 10; i++) drive("t2_sweep", digits[i], 8);

        // Test 3: 2-clock glitch while locked on 2; silent re-lock
        drive("t3_lock2", 7'h6D, 8);
        set_seg(7'h7F);
        tick();
        chk("t3_glitch_unlocked", int'(o_Locked), 0);
        tick();
        chk("t3_glitch_value", int'(o_Binary_Num), 2);
        drive("t3_return", 7'h6D, 8);

        // Test 4a: unrecognised glyph
        drive("t4_err", 7'h01, 8);

        // Test 5: blank then 3
        drive("t5_blank", 7'h00, 8);
        drive("t5_three", 7'h79, 8);

        // Test 6: hex glyph A (valid only with hex decoding)
        drive("t6_hexA", 7'h77, 8);

        // Reset asserted on the acceptance edge drops the pulse
        set_seg(7'h30);
        repeat (STABLE) tick();
        rst = 1'b1;
        tick();
        check_reset_values("t6_reset_at_accept");
        tick();
        check_reset_values("t6_reset_hold");
        rst = 1'b0;
        model_reset();

        // Test 4b: error counter saturation
        for (int i = 0; i < 300; i++) drive("t4_sat", (i % 2 == 0) ? 7'h01 : 7'h02, ACCEPT);
        chk("t4_saturated", int'(o_Error_Count), 255);

        chk("end_scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
